cntr_updn_mod: RTL and testbench

CNTR_UPDN_MOD -- requirements
Module: cntr_updn_mod

---
 rtl/cntr_pkg.sv | 25 ++
 rtl/cntr_tick_gen.sv | 43 ++++
 rtl/cntr_updn_mod.sv | 92 +++++++++
 tb/tb_cntr_updn_mod.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// cntr_pkg -- shared definitions for the up/down counter block.
//   dir_e         : count direction encoding (DIR_DOWN=0, DIR_UP=1)
//   *_MIN / *_MAX : legal parameter bounds
//   params_legal  : elaboration-time check of a WIDTH/MODULUS/PRESCALE set
package cntr_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 32;
  localparam int MODULUS_MIN  = 2;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 65535;

  // MODULUS may reach 2**32, so it is carried as a 64-bit value.
  function automatic bit params_legal(int w, longint m, int p);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
           (m >= MODULUS_MIN) && (m <= (longint'(1) << w)) &&
           (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
  endfunction

endpackage

// File: rtl/cntr_tick_gen.sv
// cntr_tick_gen -- prescaler producing one count tick every PRESCALE enabled
// cycles.
//   clk     : clock
//   rst_n   : async active-low reset
//   restart : synchronous prescaler restart (clear or load in the counter)
//   en      : count enable; the prescaler only advances while en=1
//   tick    : combinational step strobe, en AND prescaler at end of period
module cntr_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  if (PRESCALE == 1) begin : g_direct
    logic unused_direct;
    assign unused_direct = ^{clk, rst_n, restart};
    assign tick = en;
  end else begin : g_div
    localparam int            PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

    // Down-counter holding the enabled cycles left in the period:
    // remain = PRESCALE-1 - phase, so remain==0 is the last cycle of a period.
    logic [PW-1:0] remain;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        remain <= RELOAD;
      end else if (restart) begin
        remain <= RELOAD;
      end else if (en) begin
        remain <= (remain == '0) ? RELOAD : remain - PW'(1);
      end
    end

    assign tick = en && (remain == '0);
  end

endmodule

// File: rtl/cntr_updn_mod.sv
// cntr_updn_mod -- modulo up/down counter with prescaler, clear and load.
//   clk      : clock, all state on rising edge
//   rst_n    : async active-low reset
//   clr      : synchronous clear (highest priority)
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : synchronous load of min(load_val, MODULUS-1)
//   load_val : load value
//   count    : registered count, 0..MODULUS-1
//   tc       : combinational terminal count for the current direction
//   wrap     : registered one-cycle pulse after a boundary step
// Build option: CNTR_UPDN_SAT_EN -- saturate at the limits instead of
// wrapping; wrap then pulses on every tick suppressed at a limit.
module cntr_updn_mod
  import cntr_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_err
    $error("cntr_updn_mod: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  dir_e             dir;
  logic             tick;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  assign dir          = up ? DIR_UP : DIR_DOWN;
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // tc doubles as the "next step crosses a boundary" condition.
  assign tc = (dir == DIR_UP) ? (count == MAX_VAL) : (count == '0);

  cntr_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (clr | load),
    .en      (en),
    .tick    (tick)
  );

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_clamped;
    end else if (tick) begin
      if (tc) begin
        wrap_nxt = 1'b1;
`ifdef CNTR_UPDN_SAT_EN
        count_nxt = count;
`else
        count_nxt = (dir == DIR_UP) ? '0 : MAX_VAL;
`endif
      end else begin
        count_nxt = (dir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_cntr_updn_mod.sv
// tb_cntr_updn_mod -- four counter instances (defaults, MODULUS=10,
// PRESCALE=4, WIDTH=9/MODULUS=200) driven from shared inputs and checked
// against an arithmetic reference model.
module tb_cntr_updn_mod;

`ifdef CNTR_UPDN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr   = 1'b0;
  logic       en    = 1'b0;
  logic       up    = 1'b0;
  logic       load  = 1'b0;
  logic [8:0] lv9   = '0;

  logic [7:0] c0, c1, c2;
  logic [8:0] c3;
  logic [3:0] tc_v, wr_v;
  logic [8:0] cnt_o [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cntr_updn_mod u_def (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv9[7:0]), .count(c0), .tc(tc_v[0]), .wrap(wr_v[0]));

  cntr_updn_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) u_m10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv9[7:0]), .count(c1), .tc(tc_v[1]), .wrap(wr_v[1]));

  cntr_updn_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) u_ps4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv9[7:0]), .count(c2), .tc(tc_v[2]), .wrap(wr_v[2]));

  cntr_updn_mod #(.WIDTH(9), .MODULUS(200), .PRESCALE(1)) u_w9 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv9), .count(c3), .tc(tc_v[3]), .wrap(wr_v[3]));

  assign cnt_o[0] = {1'b0, c0};
  assign cnt_o[1] = {1'b0, c1};
  assign cnt_o[2] = {1'b0, c2};
  assign cnt_o[3] = c3;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] c;
    logic [31:0] ps;
    logic        w;
  } mst_t;

  mst_t mdl [4];

  function automatic int mod_of(int i);
    case (i)
      1:       return 10;
      3:       return 200;
      default: return 256;
    endcase
  endfunction

  function automatic int pre_of(int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic int lv_of(int i, logic [8:0] v);
    return (i == 3) ? int'(v) : int'(v[7:0]);
  endfunction

  function automatic mst_t model_next(mst_t s, int m, int p, int lv,
                                      bit c_clr, bit c_load, bit c_en, bit c_up);
    int   c, ps;
    bit   w;
    mst_t r;
    c  = int'(s.c);
    ps = int'(s.ps);
    w  = 1'b0;
    if (c_clr) begin
      c = 0; ps = 0;
    end else if (c_load) begin
      c = (lv > m - 1) ? m - 1 : lv; ps = 0;
    end else if (c_en) begin
      if (ps == p - 1) begin
        if (c_up && c == m - 1) begin
          w = 1'b1; c = SAT ? c : 0;
        end else if (!c_up && c == 0) begin
          w = 1'b1; c = SAT ? 0 : m - 1;
        end else begin
          c = c_up ? c + 1 : c - 1;
        end
      end
      ps = (ps + 1) % p;
    end
    r.c  = 32'(c);
    r.ps = 32'(ps);
    r.w  = w;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mdl[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        mdl[i] <= model_next(mdl[i], mod_of(i), pre_of(i), lv_of(i, lv9),
                             clr, load, en, up);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #4;
    up = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt_o[i] !== 9'd0) begin
        miscompares++;
        $display("FAIL reset count inst%0d: got %0d, want 0", i, cnt_o[i]);
      end
      vectors++;
      if (wr_v[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset wrap inst%0d: got %b, want 0", i, wr_v[i]);
      end
      vectors++;
      if (tc_v[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset tc_up inst%0d: got %b, want 0", i, tc_v[i]);
      end
    end
    up = 1'b0;
    #1;
    vectors++;
    if (tc_v !== 4'hF) begin
      miscompares++;
      $display("FAIL reset tc_down: got %b, want 1111", tc_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    int exp_c;
    bit exp_w;
    int pulses;
    pulses = 0;
    up = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      cyc();
      exp_c = SAT ? ((k > 255) ? 255 : k) : (k % 256);
      exp_w = SAT ? (k >= 256) : (k == 256);
      vectors++;
      if (c0 !== 8'(exp_c)) begin
        miscompares++;
        $display("FAIL wrap_up count step %0d: got %0d, want %0d", k, c0, exp_c);
      end
      vectors++;
      if (wr_v[0] !== exp_w) begin
        miscompares++;
        $display("FAIL wrap_up wrap step %0d: got %b, want %b", k, wr_v[0], exp_w);
      end
      if (wr_v[0] === 1'b1) pulses++;
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (cnt_o[i] !== mdl[i].c[8:0]) begin
          miscompares++;
          $display("FAIL wrap_up model count inst%0d step %0d: got %0d, want %0d",
                   i, k, cnt_o[i], mdl[i].c);
        end
        vectors++;
        if (wr_v[i] !== mdl[i].w) begin
          miscompares++;
          $display("FAIL wrap_up model wrap inst%0d step %0d: got %b, want %b",
                   i, k, wr_v[i], mdl[i].w);
        end
      end
    end
    vectors++;
    if (pulses != (SAT ? 5 : 1)) begin
      miscompares++;
      $display("FAIL wrap_up pulse count: got %0d, want %0d", pulses, SAT ? 5 : 1);
    end
  endtask

  task automatic test_load_down();
    int exp_seq [4];
    exp_seq = '{2, 1, 0, SAT ? 0 : 9};
    up = 1'b0; en = 1'b1; lv9 = 9'd3; load = 1'b1;
    cyc();
    load = 1'b0;
    vectors++;
    if (c1 !== 8'd3 || tc_v[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL load_down load: got count %0d tc %b, want 3 tc 0", c1, tc_v[1]);
    end
    for (int j = 0; j < 4; j++) begin
      cyc();
      vectors++;
      if (c1 !== 8'(exp_seq[j])) begin
        miscompares++;
        $display("FAIL load_down count %0d: got %0d, want %0d", j, c1, exp_seq[j]);
      end
      vectors++;
      if (tc_v[1] !== (exp_seq[j] == 0)) begin
        miscompares++;
        $display("FAIL load_down tc %0d: got %b, want %b", j, tc_v[1], exp_seq[j] == 0);
      end
      vectors++;
      if (wr_v[1] !== (j == 3)) begin
        miscompares++;
        $display("FAIL load_down wrap %0d: got %b, want %b", j, wr_v[1], j == 3);
      end
    end
  endtask

  task automatic test_prescale();
    clr = 1'b1; en = 1'b1; up = 1'b1;
    cyc();
    clr = 1'b0;
    vectors++;
    if (c2 !== 8'd0) begin
      miscompares++;
      $display("FAIL prescale clr: got %0d, want 0", c2);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      vectors++;
      if (c2 !== 8'(k / 4)) begin
        miscompares++;
        $display("FAIL prescale run edge %0d: got %0d, want %0d", k, c2, k / 4);
      end
    end
    en = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      cyc();
      vectors++;
      if (c2 !== 8'd2) begin
        miscompares++;
        $display("FAIL prescale hold %0d: got %0d, want 2", k, c2);
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      vectors++;
      if (c2 !== 8'(2 + (j + 2) / 4)) begin
        miscompares++;
        $display("FAIL prescale resume %0d: got %0d, want %0d", j, c2, 2 + (j + 2) / 4);
      end
      vectors++;
      if (wr_v[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL prescale wrap %0d: got %b, want 0", j, wr_v[2]);
      end
    end
  endtask

  task automatic test_clr_load();
    clr = 1'b1; load = 1'b1; lv9 = 9'h055;
    cyc();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt_o[i] !== 9'd0 || wr_v[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_over_load inst%0d: got count %0d wrap %b, want 0 0",
                 i, cnt_o[i], wr_v[i]);
      end
    end
    clr = 1'b0; lv9 = 9'd300;
    cyc();
    load = 1'b0;
    vectors++;
    if (c3 !== 9'd199) begin
      miscompares++;
      $display("FAIL load_clamp w9: got %0d, want 199", c3);
    end
    vectors++;
    if (c1 !== 8'd9) begin
      miscompares++;
      $display("FAIL load_clamp m10: got %0d, want 9", c1);
    end
    vectors++;
    if (c0 !== 8'd44 || c2 !== 8'd44) begin
      miscompares++;
      $display("FAIL load_trunc: got %0d/%0d, want 44/44", c0, c2);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; lv9 = 9'h07E;
    cyc();
    load = 1'b0; en = 1'b1; up = 1'b1;
    vectors++;
    if (c0 !== 8'h7E) begin
      miscompares++;
      $display("FAIL async_reset preload: got %0h, want 7e", c0);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt_o[i] !== 9'd0 || wr_v[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL async_reset inst%0d: got count %0d wrap %b, want 0 0",
                 i, cnt_o[i], wr_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      cyc();
      vectors++;
      if (c2 !== ((j == 4) ? 8'd1 : 8'd0)) begin
        miscompares++;
        $display("FAIL async_reset prescaler restart %0d: got %0d, want %0d",
                 j, c2, (j == 4) ? 1 : 0);
      end
      vectors++;
      if (c0 !== 8'(j)) begin
        miscompares++;
        $display("FAIL async_reset resume %0d: got %0d, want %0d", j, c0, j);
      end
    end
  endtask

  task automatic test_random();
    bit exp_tc;
    for (int n = 0; n < 400; n++) begin
      clr  = ($urandom % 25) == 0;
      load = ($urandom % 15) == 0;
      en   = ($urandom % 4) != 0;
      if (($urandom % 10) == 0) up = ~up;
      lv9  = 9'($urandom % 512);
      cyc();
      for (int i = 0; i < 4; i++) begin
        exp_tc = up ? (int'(mdl[i].c) == mod_of(i) - 1) : (mdl[i].c == 0);
        vectors++;
        if (cnt_o[i] !== mdl[i].c[8:0]) begin
          miscompares++;
          $display("FAIL random count inst%0d cyc %0d: got %0d, want %0d",
                   i, n, cnt_o[i], mdl[i].c);
        end
        vectors++;
        if (wr_v[i] !== mdl[i].w) begin
          miscompares++;
          $display("FAIL random wrap inst%0d cyc %0d: got %b, want %b",
                   i, n, wr_v[i], mdl[i].w);
        end
        vectors++;
        if (tc_v[i] !== exp_tc) begin
          miscompares++;
          $display("FAIL random tc inst%0d cyc %0d: got %b, want %b",
                   i, n, tc_v[i], exp_tc);
        end
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

`ifdef CNTR_UPDN_SAT_EN
  task automatic test_sat();
    int exp_c [3];
    bit exp_w [3];
    exp_c = '{255, 255, 254};
    exp_w = '{1'b0, 1'b1, 1'b0};
    clr = 1'b0; load = 1'b1; lv9 = 9'd254; en = 1'b1; up = 1'b1;
    cyc();
    load = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) up = 1'b0;
      cyc();
      vectors++;
      if (c0 !== 8'(exp_c[j]) || wr_v[0] !== exp_w[j]) begin
        miscompares++;
        $display("FAIL sat step %0d: got count %0d wrap %b, want %0d %b",
                 j, c0, wr_v[0], exp_c[j], exp_w[j]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_up();
    test_load_down();
    test_prescale();
    test_clr_load();
    test_async_reset();
    test_random();
`ifdef CNTR_UPDN_SAT_EN
    test_sat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
